// File: rtl/parallax_scroll_ctrl_pkg.sv
// parallax_scroll_ctrl_pkg
//   Shared definitions for the parallax scroll controller: window geometry,
//   command opcodes, FSM state type, live-config struct and reset values,
//   plus small helpers for payload conditioning and pixel-step decode.
//   Optional feature macro: PARALLAX_PAUSE_EN (adds the PAUSED state).
package parallax_scroll_ctrl_pkg;

    localparam logic [9:0] H_WIN     = 10'd256;
    localparam logic [9:0] V_WIN     = 10'd256;
    localparam logic [9:0] PRE_LINE  = 10'd1;
    localparam logic [2:0] MAX_SPEED = 3'd7;

    localparam logic [1:0] OP_SPEED0 = 2'd0;
    localparam logic [1:0] OP_SPEED1 = 2'd1;
    localparam logic [1:0] OP_DIV    = 2'd2;
    localparam logic [1:0] OP_PAUSE  = 2'd3;

    localparam logic [2:0] SPEED0_RST = 3'd3;
    localparam logic [2:0] SPEED1_RST = 3'd1;
    // layer2 = 2 (every 4 px), layer1 = 1 (every 2 px), layer0 = 0 (every px)
    localparam logic [5:0] DIV_RST    = 6'b10_01_00;

`ifdef PARALLAX_PAUSE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_e;
`endif

    typedef struct packed {
        logic [2:0] speed0;
        logic [2:0] speed1;
        logic [5:0] div;
        logic       pause;
    } live_cfg_t;

    localparam live_cfg_t CFG_RST = '{
        speed0: SPEED0_RST,
        speed1: SPEED1_RST,
        div:    DIV_RST,
        pause:  1'b0
    };

    // The whole payload byte is compared so that e.g. 9 saturates to 7
    // instead of wrapping to 1 through truncation.
    function automatic logic [2:0] sat_speed(input logic [7:0] data);
        logic [2:0] s;
        s = (data > {5'd0, MAX_SPEED}) ? MAX_SPEED : data[2:0];
        return s;
    endfunction

    function automatic logic [1:0] clamp_div(input logic [1:0] f);
        logic [1:0] c;
        c = (f == 2'd3) ? 2'd2 : f;
        return c;
    endfunction

    // True when the pixel lands on a step boundary of 2^div pixels.
    function automatic logic step_hit(input logic [1:0] hpos_lsb, input logic [1:0] div);
        logic hit;
        case (div)
            2'd0:    hit = 1'b1;
            2'd1:    hit = ~hpos_lsb[0];
            default: hit = (hpos_lsb == 2'b00);
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/parallax_cmd_shadow.sv
// parallax_cmd_shadow
//   One-entry shadow bank for host commands. A command is accepted when
//   cmd_valid_i & cmd_ready_o; it is held pending and copied into the live
//   configuration at the next frame start (fs_i), which frees the bank.
//   Optional feature macro: PARALLAX_PAUSE_EN (PAUSE op updates live pause;
//   otherwise op 3 only consumes the bank).
// Ports
//   clk_i, reset_i   pixel clock, synchronous active-high reset
//   fs_i             frame start (hpos==0 && vpos==0)
//   cmd_valid_i      command present
//   cmd_op_i [1:0]   opcode
//   cmd_data_i [7:0] payload
//   cmd_ready_o      bank free
//   live_cfg_o       live configuration (registered)
//   pause_next_o     pause bit the live config will hold after this cycle
module parallax_cmd_shadow
    import parallax_scroll_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       fs_i,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output live_cfg_t  live_cfg_o,
    output logic       pause_next_o
);

    logic       pending_q, pending_d;
    logic [1:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    live_cfg_t  live_q, live_d;
    live_cfg_t  applied;
    logic       accept;

    assign accept = cmd_valid_i && !pending_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= 1'b0;
            op_q      <= '0;
            data_q    <= '0;
            live_q    <= CFG_RST;
        end else begin
            pending_q <= pending_d;
            op_q      <= op_d;
            data_q    <= data_d;
            live_q    <= live_d;
        end
    end

    // Live config with the pending command merged in.
    always_comb begin
        applied = live_q;
        case (op_q)
            OP_SPEED0: applied.speed0 = sat_speed(data_q);
            OP_SPEED1: applied.speed1 = sat_speed(data_q);
            OP_DIV:    applied.div    = {clamp_div(data_q[5:4]),
                                         clamp_div(data_q[3:2]),
                                         clamp_div(data_q[1:0])};
            OP_PAUSE: begin
`ifdef PARALLAX_PAUSE_EN
                applied.pause = data_q[0];
`endif
            end
            default: ;
        endcase
    end

    // Apply-at-fs happens before the accept update; a command accepted on
    // the fs cycle can only arrive with the bank empty, so it simply lands
    // and waits for the following fs.
    always_comb begin
        pending_d = pending_q;
        op_d      = op_q;
        data_d    = data_q;
        live_d    = live_q;
        if (fs_i && pending_q) begin
            live_d    = applied;
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
            op_d      = cmd_op_i;
            data_d    = cmd_data_i;
        end
    end

    assign cmd_ready_o  = !pending_q;
    assign live_cfg_o   = live_q;
    assign pause_next_o = live_d.pause;

endmodule

// File: rtl/parallax_scroll_ctrl.sv
// parallax_scroll_ctrl
//   Frame-level sequencer for the scrolling procedural background. Decodes
//   per-pixel star-layer step enables, per-frame mountain pre-advance pulses,
//   frame-start reseed and the frame counter from hpos/vpos and the live
//   configuration held in parallax_cmd_shadow.
//   Optional feature macro: PARALLAX_PAUSE_EN (adds PAUSED state).
//
//   state  | meaning
//   IDLE   | after reset, all enables low until first frame start
//   RUN    | normal scrolling, frame counts
//   PAUSED | stars still step, ridges frozen, frame holds (pause build only)
//
// Ports
//   clk_i, reset_i      pixel clock, synchronous active-high reset
//   hpos_i, vpos_i      pixel position from the sync generator
//   cmd_valid_i/op/data host command port; cmd_ready_o bank free
//   win_en_o            pixel inside the star/mountain window
//   layer_en_o [2:0]    star-layer LFSR step enables
//   pre_step_o [1:0]    mountain-layer pre-advance pulses
//   seed_load_o         reseed pulse at frame start
//   frame_o [4:0]       frame counter
//   running_o           FSM in RUN
module parallax_scroll_ctrl
    import parallax_scroll_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] hpos_i,
    input  logic [9:0] vpos_i,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       win_en_o,
    output logic [2:0] layer_en_o,
    output logic [1:0] pre_step_o,
    output logic       seed_load_o,
    output logic [4:0] frame_o,
    output logic       running_o
);

    logic       fs;
    live_cfg_t  live_cfg;
    logic       pause_next;
    state_e     state_q, state_d;
    logic [4:0] frame_q, frame_d;
    logic       active;
    logic       on_pre_line;

    assign fs = (hpos_i == 10'd0) && (vpos_i == 10'd0);

    parallax_cmd_shadow u_shadow (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .fs_i         (fs),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_op_i     (cmd_op_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_ready_o  (cmd_ready_o),
        .live_cfg_o   (live_cfg),
        .pause_next_o (pause_next)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    // Pause decisions use the config as it stands after this fs, so a
    // PAUSE command takes effect at the first fs after acceptance.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: if (fs) state_d = ST_RUN;
`ifdef PARALLAX_PAUSE_EN
            ST_RUN:    if (fs && pause_next)  state_d = ST_PAUSED;
            ST_PAUSED: if (fs && !pause_next) state_d = ST_RUN;
`else
            ST_RUN:  state_d = ST_RUN;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (fs && (state_d == ST_RUN)) begin
            frame_d = frame_q + 5'd1;
        end
    end

`ifndef PARALLAX_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_next ^ live_cfg.pause;
`endif

    assign active      = (state_q != ST_IDLE);
    assign on_pre_line = (vpos_i == PRE_LINE);

    assign win_en_o      = active && (hpos_i < H_WIN) && (vpos_i < V_WIN);
    assign layer_en_o[0] = win_en_o && step_hit(hpos_i[1:0], live_cfg.div[1:0]);
    assign layer_en_o[1] = win_en_o && step_hit(hpos_i[1:0], live_cfg.div[3:2]);
    assign layer_en_o[2] = win_en_o && step_hit(hpos_i[1:0], live_cfg.div[5:4]);

    assign running_o     = (state_q == ST_RUN);
    assign pre_step_o[0] = running_o && on_pre_line && (hpos_i < {7'd0, live_cfg.speed0});
    assign pre_step_o[1] = running_o && on_pre_line && (hpos_i < {7'd0, live_cfg.speed1});

    assign seed_load_o = fs && !reset_i;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_parallax_scroll_ctrl.sv
module tb_parallax_scroll_ctrl;

`ifdef PARALLAX_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int MODE_IDLE   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_PAUSED = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, win_en, seed_load, running;
    logic [2:0] layer_en;
    logic [1:0] pre_step;
    logic [4:0] frame;

    parallax_scroll_ctrl dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .hpos_i      (hpos),
        .vpos_i      (vpos),
        .cmd_valid_i (cmd_valid),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .cmd_ready_o (cmd_ready),
        .win_en_o    (win_en),
        .layer_en_o  (layer_en),
        .pre_step_o  (pre_step),
        .seed_load_o (seed_load),
        .frame_o     (frame),
        .running_o   (running)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // current stimulus
    bit in_rst, in_vld;
    int in_h, in_v, in_op, in_dat;

    // reference model
    int m_mode, m_frame, m_pop, m_pdata;
    int m_speed[2];
    int m_div[3];
    bit m_pause, m_pend, m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (h=%0d v=%0d t=%0t)", name, act, exp, in_h, in_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MODE_IDLE;
        m_frame = 0;
        m_speed[0] = 3;
        m_speed[1] = 1;
        m_div[0] = 0;
        m_div[1] = 1;
        m_div[2] = 2;
        m_pause = 1'b0;
        m_pend = 1'b0;
        m_pop = 0;
        m_pdata = 0;
    endtask

    task automatic model_apply(input int op, input int data);
        int f;
        case (op)
            0: m_speed[0] = (data > 7) ? 7 : data;
            1: m_speed[1] = (data > 7) ? 7 : data;
            2: for (int i = 0; i < 3; i++) begin
                   f = (data >> (2 * i)) & 3;
                   m_div[i] = (f == 3) ? 2 : f;
               end
            default: if (PAUSE_EN) m_pause = data[0];
        endcase
    endtask

    task automatic model_step();
        bit fs, acc;
        m_acc = 1'b0;
        if (in_rst) begin
            model_reset();
            return;
        end
        fs  = (in_h == 0) && (in_v == 0);
        acc = in_vld && !m_pend;
        if (fs) begin
            if (m_pend) begin
                model_apply(m_pop, m_pdata);
                m_pend = 1'b0;
            end
            if (m_mode == MODE_IDLE) m_mode = MODE_RUN;
            else if (m_mode == MODE_RUN && PAUSE_EN && m_pause) m_mode = MODE_PAUSED;
            else if (m_mode == MODE_PAUSED && !m_pause) m_mode = MODE_RUN;
            if (m_mode == MODE_RUN) m_frame = (m_frame + 1) % 32;
        end
        if (acc) begin
            m_pend = 1'b1;
            m_pop = in_op;
            m_pdata = in_dat;
            m_acc = 1'b1;
        end
    endtask

    task automatic model_check();
        bit w;
        logic [2:0] le;
        logic [1:0] ps;
        w = (m_mode != MODE_IDLE) && (in_h < 256) && (in_v < 256);
        for (int i = 0; i < 3; i++) le[i] = w && ((in_h % (1 << m_div[i])) == 0);
        for (int k = 0; k < 2; k++) ps[k] = (m_mode == MODE_RUN) && (in_v == 1) && (in_h < m_speed[k]);
        chk("win_en", 32'(win_en), 32'(w));
        chk("layer_en", 32'(layer_en), 32'(le));
        chk("pre_step", 32'(pre_step), 32'(ps));
        chk("seed_load", 32'(seed_load), 32'((in_h == 0) && (in_v == 0) && !in_rst));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_pend));
        chk("running", 32'(running), 32'(m_mode == MODE_RUN));
        chk("frame", 32'(frame), 32'(m_frame));
    endtask

    task automatic apply_in(input bit r, input int h, input int v, input bit vl,
                            input int op, input int dat, input bit do_chk);
        @(negedge clk);
        in_rst = r; in_h = h; in_v = v; in_vld = vl; in_op = op; in_dat = dat;
        rst = r;
        hpos = h[9:0];
        vpos = v[9:0];
        cmd_valid = vl;
        cmd_op = op[1:0];
        cmd_data = dat[7:0];
        #1;
        if (do_chk) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        bit         r;
        int         h;
        int         v;
        logic       win;
        logic [2:0] layer;
        logic [1:0] pre;
        logic       seed;
        logic       ready;
        logic       run;
        logic [4:0] frm;
    } vec_t;

    vec_t vecs[12];
    int fr0;
    bit hv;
    int hop, hdat;

    initial begin
        vecs[0]  = '{0, 10,  3,   0, 3'b000, 2'b00, 0, 1, 0, 5'd0};
        vecs[1]  = '{0, 0,   0,   0, 3'b000, 2'b00, 1, 1, 0, 5'd0};
        vecs[2]  = '{0, 0,   1,   1, 3'b111, 2'b11, 0, 1, 1, 5'd1};
        vecs[3]  = '{0, 1,   1,   1, 3'b001, 2'b01, 0, 1, 1, 5'd1};
        vecs[4]  = '{0, 2,   1,   1, 3'b011, 2'b01, 0, 1, 1, 5'd1};
        vecs[5]  = '{0, 3,   1,   1, 3'b001, 2'b00, 0, 1, 1, 5'd1};
        vecs[6]  = '{0, 4,   1,   1, 3'b111, 2'b00, 0, 1, 1, 5'd1};
        vecs[7]  = '{0, 252, 5,   1, 3'b111, 2'b00, 0, 1, 1, 5'd1};
        vecs[8]  = '{0, 256, 5,   0, 3'b000, 2'b00, 0, 1, 1, 5'd1};
        vecs[9]  = '{0, 8,   256, 0, 3'b000, 2'b00, 0, 1, 1, 5'd1};
        vecs[10] = '{0, 0,   0,   1, 3'b111, 2'b00, 1, 1, 1, 5'd1};
        vecs[11] = '{0, 0,   1,   1, 3'b111, 2'b11, 0, 1, 1, 5'd2};

        model_reset();
        apply_in(1, 7, 7, 0, 0, 0, 0);
        advance();
        apply_in(1, 7, 7, 0, 0, 0, 1);
        advance();

        // reset state and two frames with no commands
        for (int i = 0; i < 12; i++) begin
            apply_in(vecs[i].r, vecs[i].h, vecs[i].v, 0, 0, 0, 1);
            chk("tbl_win", 32'(win_en), 32'(vecs[i].win));
            chk("tbl_layer", 32'(layer_en), 32'(vecs[i].layer));
            chk("tbl_pre", 32'(pre_step), 32'(vecs[i].pre));
            chk("tbl_seed", 32'(seed_load), 32'(vecs[i].seed));
            chk("tbl_ready", 32'(cmd_ready), 32'(vecs[i].ready));
            chk("tbl_run", 32'(running), 32'(vecs[i].run));
            chk("tbl_frame", 32'(frame), 32'(vecs[i].frm));
            advance();
        end

        // SPEED1 = 5 mid-frame
        apply_in(0, 100, 1, 1, 1, 5, 1);
        chk("spd1_ready_before", 32'(cmd_ready), 32'd1);
        advance();
        apply_in(0, 101, 1, 0, 0, 0, 1);
        chk("spd1_ready_pending", 32'(cmd_ready), 32'd0);
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        advance();
        for (int h = 0; h < 7; h++) begin
            apply_in(0, h, 1, 0, 0, 0, 1);
            if (h == 0) chk("spd1_ready_after", 32'(cmd_ready), 32'd1);
            chk("spd1_pre1", 32'(pre_step[1]), 32'(h < 5));
            advance();
        end

        // SPEED0 = 9 accepted on the fs cycle: applies one frame later
        apply_in(0, 0, 0, 1, 0, 9, 1);
        chk("fscmd_seed", 32'(seed_load), 32'd1);
        advance();
        apply_in(0, 3, 1, 0, 0, 0, 1);
        chk("fscmd_pre0_old", 32'(pre_step[0]), 32'd0);
        advance();
        apply_in(0, 4, 1, 0, 0, 0, 1);
        chk("fscmd_ready", 32'(cmd_ready), 32'd0);
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        advance();
        apply_in(0, 3, 1, 0, 0, 0, 1);
        chk("fscmd_pre0_h3", 32'(pre_step[0]), 32'd1);
        advance();
        apply_in(0, 6, 1, 0, 0, 0, 1);
        chk("fscmd_pre0_h6", 32'(pre_step[0]), 32'd1);
        advance();
        apply_in(0, 7, 1, 0, 0, 0, 1);
        chk("fscmd_pre0_h7", 32'(pre_step[0]), 32'd0);
        advance();

        // PAUSE = 1 then PAUSE = 0
        apply_in(0, 50, 5, 1, 3, 1, 1);
        advance();
        fr0 = m_frame;
        apply_in(0, 0, 0, 0, 0, 0, 1);
        advance();
        apply_in(0, 0, 1, 0, 0, 0, 1);
        chk("pause_layer", 32'(layer_en), 32'b111);
        chk("pause_running", 32'(running), PAUSE_EN ? 32'd0 : 32'd1);
        chk("pause_pre", 32'(pre_step), PAUSE_EN ? 32'd0 : 32'd3);
        chk("pause_frame1", 32'(frame), 32'(PAUSE_EN ? fr0 : (fr0 + 1) % 32));
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        chk("pause_seed", 32'(seed_load), 32'd1);
        advance();
        apply_in(0, 2, 1, 0, 0, 0, 1);
        chk("pause_frame2", 32'(frame), 32'(PAUSE_EN ? fr0 : (fr0 + 2) % 32));
        chk("pause_pre2", 32'(pre_step), PAUSE_EN ? 32'd0 : 32'd3);
        advance();
        apply_in(0, 20, 2, 1, 3, 0, 1);
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        advance();
        apply_in(0, 0, 1, 0, 0, 0, 1);
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_frame", 32'(frame), 32'(PAUSE_EN ? (fr0 + 1) % 32 : (fr0 + 3) % 32));
        advance();

        // reset mid-frame with a command pending
        apply_in(0, 80, 50, 1, 2, 0, 1);
        advance();
        apply_in(0, 90, 50, 0, 0, 0, 1);
        chk("rst_pending", 32'(cmd_ready), 32'd0);
        advance();
        apply_in(1, 100, 50, 0, 0, 0, 1);
        advance();
        apply_in(1, 0, 0, 0, 0, 0, 1);
        chk("rst_seed_low", 32'(seed_load), 32'd0);
        advance();
        apply_in(0, 101, 50, 0, 0, 0, 1);
        chk("rst_frame", 32'(frame), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_win", 32'(win_en), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        advance();
        apply_in(0, 0, 1, 0, 0, 0, 1);
        chk("rst_inert", 32'({win_en, layer_en, pre_step}), 32'd0);
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        chk("rst_fs_seed", 32'(seed_load), 32'd1);
        chk("rst_fs_win", 32'(win_en), 32'd0);
        advance();
        apply_in(0, 0, 1, 0, 0, 0, 1);
        chk("rst_after_win", 32'(win_en), 32'd1);
        chk("rst_after_frame", 32'(frame), 32'd1);
        advance();

        // DIV = 11_00_00: layer2 every 4 px, layers 0/1 every px
        apply_in(0, 5, 5, 1, 2, 8'b0011_0000, 1);
        advance();
        apply_in(0, 0, 0, 0, 0, 0, 1);
        advance();
        for (int h = 0; h < 8; h++) begin
            apply_in(0, h, 3, 0, 0, 0, 1);
            chk("div_layer", 32'(layer_en), 32'({(h % 4) == 0, 2'b11}));
            advance();
        end

        // randomized traffic against the model
        hv = 1'b0;
        hop = 0;
        hdat = 0;
        for (int n = 0; n < 4000; n++) begin
            int h, v, r;
            bit rr;
            r = $urandom_range(0, 99);
            if (r < 40)      h = $urandom_range(0, 9);
            else if (r < 80) h = $urandom_range(0, 520);
            else             h = $urandom_range(250, 260);
            r = $urandom_range(0, 99);
            if (r < 20)      v = 0;
            else if (r < 55) v = 1;
            else             v = $urandom_range(0, 300);
            if (n % 25 == 0) begin
                h = 0;
                v = 0;
            end
            rr = ($urandom_range(0, 399) == 0);
            if (!hv && $urandom_range(0, 5) == 0) begin
                hv = 1'b1;
                hop = $urandom_range(0, 3);
                hdat = $urandom_range(0, 255);
            end
            apply_in(rr, h, v, hv, hop, hdat, 1);
            advance();
            if (m_acc) hv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
